// File: rtl/lab_pkg.sv
// Shared lab definitions.
//   state_t    : sequencer state encoding (IDLE, RUN, DONE)
//   SEG_BLANK  : all segments off (active-low)
//   SEG_DIGIT  : active-low seven-segment patterns for decimal 0..9,
//                bit0 = seg a .. bit6 = seg g, bit7 = DP (off)
package lab_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [7:0] SEG_DIGIT [10] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
    8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };

endpackage

// File: rtl/seg7_decoder.sv
// Seven-segment decoder for one active-low digit.
//   value : 4-bit value to show (0..9 displayed, 10..15 shown blank)
//   blank : 1 forces the digit dark
//   seg   : active-low segments, bit0 = a .. bit6 = g, bit7 = DP (held off)
module seg7_decoder
  import lab_pkg::*;
(
  input  logic [3:0] value,
  input  logic       blank,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank && (value < 4'd10)) begin
      seg = SEG_DIGIT[value];
    end
  end

endmodule

// File: rtl/truth_table_tester.sv
// Self-test sequencer for a small combinational lab circuit.
// Steps stim through every input code, holds each for SETTLE cycles,
// samples dut_out on the edge that advances stim and compares it with
// EXPECTED[code]. Results are held until the next start.
//   MAX10_CLK1_50 : clock
//   rst_n         : asynchronous active-low reset
//   start         : level-sampled run request (ignored while running)
//   dut_out       : output of the circuit under test
//   stim          : stimulus to the circuit under test
//   busy / done   : run in progress / results valid
//   pass          : done with zero mismatches
//   fail_mask     : bit i set when code i mismatched
//   fail_count    : number of mismatching codes
//   HEX0          : fail_count in decimal once done, blank otherwise
module truth_table_tester
  import lab_pkg::*;
#(
  parameter int                 N_IN     = 3,
  parameter logic [2**N_IN-1:0] EXPECTED = 8'b1110_1000,
  parameter int                 SETTLE   = 4
)(
  input  logic                MAX10_CLK1_50,
  input  logic                rst_n,
  input  logic                start,
  input  logic                dut_out,
  output logic [N_IN-1:0]     stim,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [2**N_IN-1:0]  fail_mask,
  output logic [N_IN:0]       fail_count,
  output logic [7:0]          HEX0
);

  localparam int CW = $clog2(SETTLE) + 1;

  state_t          state;
  logic [N_IN-1:0] vec;
  logic [CW-1:0]   cnt;

  logic sample;
  logic miss;
  logic last_vec;

  always_comb begin
    sample   = (cnt == CW'(SETTLE - 1));
    miss     = sample && (dut_out != EXPECTED[vec]);
    last_vec = (vec == '1);
  end

  always_ff @(posedge MAX10_CLK1_50 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      vec        <= '0;
      cnt        <= '0;
      stim       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_mask  <= '0;
      fail_count <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= RUN;
            vec        <= '0;
            cnt        <= '0;
            stim       <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_mask  <= '0;
            fail_count <= '0;
          end
        end
        RUN: begin
          if (sample) begin
            cnt <= '0;
            if (miss) begin
              fail_mask[vec] <= 1'b1;
              fail_count     <= fail_count + (N_IN+1)'(1);
            end
            if (!last_vec) begin
              vec  <= vec + N_IN'(1);
              stim <= vec + N_IN'(1);
            end else begin
              // pass must include the final sample, which lands in fail_count on this same edge
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (fail_count == '0) && !miss;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  seg7_decoder u_hex0 (
    .value (4'(fail_count)),
    .blank (!done),
    .seg   (HEX0)
  );

endmodule

// File: tb/tb_truth_table_tester.sv
module tb_truth_table_tester;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start_a, start_b;
  int         mode;

  logic [2:0] stim_a, stim_b;
  logic       dout_a, dout_b;
  logic       busy_a, done_a, pass_a, busy_b, done_b, pass_b;
  logic [7:0] mask_a, mask_b, hex_a, hex_b;
  logic [3:0] cnt_a, cnt_b;

  int tests = 0;
  int fails = 0;

  function automatic logic maj(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

  // mode 0: majority, 1: stuck at 0, 2: inverted majority
  assign dout_a = (mode == 0) ? maj(stim_a) : (mode == 1) ? 1'b0 : ~maj(stim_a);
  assign dout_b = maj(stim_b);

  truth_table_tester #(.N_IN(3), .EXPECTED(8'b1110_1000), .SETTLE(4)) dut_a (
    .MAX10_CLK1_50 (clk),
    .rst_n         (rst_n),
    .start         (start_a),
    .dut_out       (dout_a),
    .stim          (stim_a),
    .busy          (busy_a),
    .done          (done_a),
    .pass          (pass_a),
    .fail_mask     (mask_a),
    .fail_count    (cnt_a),
    .HEX0          (hex_a)
  );

  truth_table_tester #(.N_IN(3), .EXPECTED(8'b1110_1000), .SETTLE(1)) dut_b (
    .MAX10_CLK1_50 (clk),
    .rst_n         (rst_n),
    .start         (start_b),
    .dut_out       (dout_b),
    .stim          (stim_b),
    .busy          (busy_b),
    .done          (done_b),
    .pass          (pass_b),
    .fail_mask     (mask_b),
    .fail_count    (cnt_b),
    .HEX0          (hex_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int         mode;
    logic [7:0] mask;
    logic [3:0] count;
    logic       pass;
    logic [7:0] hex;
  } vec_t;

  vec_t tbl [3];

  // Start a run on dut_a, follow it to done and check the results.
  task automatic run_a(input bit hold, input vec_t v);
    int  cycles;
    bit  seq_ok;
    mode = v.mode;
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk); #1;
    if (!hold) start_a = 1'b0;
    chk("start_busy", busy_a, 1);
    chk("start_stim", stim_a, 0);
    chk("start_clear", {done_a, pass_a, mask_a, cnt_a, hex_a}, {1'b0, 1'b0, 8'h00, 4'h0, 8'hFF});
    seq_ok = 1'b1;
    cycles = 0;
    for (int j = 1; j <= 100; j++) begin
      @(posedge clk); #1;
      cycles = j;
      if (done_a) break;
      if (stim_a !== 3'(j / 4) || busy_a !== 1'b1) seq_ok = 1'b0;
    end
    start_a = 1'b0;
    chk("stim_sequence", seq_ok, 1);
    chk("done_latency", cycles, 32);
    chk("done_flag", {busy_a, done_a}, 2'b01);
    chk("stim_held", stim_a, 7);
    chk("pass", pass_a, v.pass);
    chk("fail_mask", mask_a, v.mask);
    chk("fail_count", cnt_a, v.count);
    chk("hex0", hex_a, v.hex);
  endtask

  initial begin
    tbl[0] = '{mode: 0, mask: 8'h00, count: 4'd0, pass: 1'b1, hex: 8'hC0};
    tbl[1] = '{mode: 1, mask: 8'hE8, count: 4'd4, pass: 1'b0, hex: 8'h99};
    tbl[2] = '{mode: 2, mask: 8'hFF, count: 4'd8, pass: 1'b0, hex: 8'h80};

    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; mode = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {stim_a, busy_a, done_a, pass_a, mask_a, cnt_a, hex_a},
        {3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 8'hFF});
    @(negedge clk);
    rst_n = 1'b1;

    // idle with start low: nothing happens
    repeat (3) @(posedge clk);
    #1;
    chk("idle_busy", busy_a, 0);

    for (int i = 0; i < 3; i++) run_a(1'b0, tbl[i]);

    // start held through a whole run, then a restart with different results
    run_a(1'b1, tbl[0]);
    repeat (2) @(posedge clk);
    #1;
    chk("done_holds", {done_a, pass_a, hex_a}, {1'b1, 1'b1, 8'hC0});
    run_a(1'b0, tbl[1]);

    // asynchronous reset partway through a run
    mode = 2;
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (13) @(posedge clk);
    #2;
    chk("midrun_mask", mask_a, 8'h07);
    rst_n = 1'b0;
    #1;
    chk("async_reset", {stim_a, busy_a, done_a, pass_a, mask_a, cnt_a, hex_a},
        {3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0, 8'hFF});
    @(negedge clk);
    rst_n = 1'b1;
    begin
      bit stay_idle = 1'b1;
      repeat (5) begin
        @(posedge clk); #1;
        if (busy_a !== 1'b0 || done_a !== 1'b0) stay_idle = 1'b0;
      end
      chk("idle_after_reset", stay_idle, 1);
    end

    // SETTLE = 1 instance
    begin
      int cycles = 0;
      bit seq_ok = 1'b1;
      @(negedge clk);
      start_b = 1'b1;
      @(posedge clk); #1;
      start_b = 1'b0;
      chk("s1_start", {busy_b, stim_b}, {1'b1, 3'd0});
      for (int j = 1; j <= 50; j++) begin
        @(posedge clk); #1;
        cycles = j;
        if (done_b) break;
        if (stim_b !== 3'(j)) seq_ok = 1'b0;
      end
      chk("s1_stim_sequence", seq_ok, 1);
      chk("s1_done_latency", cycles, 8);
      chk("s1_results", {busy_b, done_b, pass_b, mask_b, cnt_b, hex_b},
          {1'b0, 1'b1, 1'b1, 8'h00, 4'h0, 8'hC0});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
